// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: sizes, ALU op encoding
// and reset fill value.
package cpu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 8;

  localparam logic RST_BIT = 1'b0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_XOR = 2'd2
  } alu_op_t;

  // xorctrl dominates addsub
  function automatic alu_op_t alu_decode(input logic addsub, input logic xorctrl);
    if (xorctrl)     return ALU_XOR;
    else if (addsub) return ALU_SUB;
    else             return ALU_ADD;
  endfunction

endpackage

// File: rtl/cpu_datapath_reg_en.sv
// Enable register with asynchronous active-high reset; used for R0..R7, G and A.
module reg_en #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  import cpu_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= {WIDTH{RST_BIT}};
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu_datapath.sv
// Register file, shared bus, ALU, flags and PC of the 16-bit multicycle CPU,
// driven by the control unit's per-cycle control word.
module cpu_datapath #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned NREGS = cpu_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] rin,
  input  logic [NREGS-1:0] rout,
  input  logic             gin,
  input  logic             gout,
  input  logic             pcin,
  input  logic             pcout,
  input  logic             addsub,
  input  logic             xorctrl,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] instr_addr,
  output logic [WIDTH-1:0] bus,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             bus_err
);

  import cpu_pkg::*;

  logic [WIDTH-1:0] r_q [NREGS];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum;
  logic             contention;
  alu_op_t          alu_op;

  for (genvar k = 0; k < NREGS; k++) begin : g_regs
    reg_en #(.WIDTH(WIDTH)) u_r (
      .clk (clk),
      .rst (rst),
      .en  (rin[k]),
      .d   (bus),
      .q   (r_q[k])
    );
  end

  reg_en #(.WIDTH(WIDTH)) u_g (
    .clk (clk),
    .rst (rst),
    .en  (gin),
    .d   (alu_res),
    .q   (g_q)
  );

  reg_en #(.WIDTH(WIDTH)) u_a (
    .clk (clk),
    .rst (rst),
    .en  (~gin),
    .d   (bus),
    .q   (a_q)
  );

  // OR of all selected sources is only forwarded when exactly one drives
  always_comb begin
    int unsigned      cnt;
    logic [WIDTH-1:0] sel_or;
    cnt    = 0;
    sel_or = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (rout[k]) begin
        cnt    = cnt + 1;
        sel_or = sel_or | r_q[k];
      end
    end
    if (gout) begin
      cnt    = cnt + 1;
      sel_or = sel_or | g_q;
    end
    if (pcout) begin
      cnt    = cnt + 1;
      sel_or = sel_or | pc_q;
    end
    contention = (cnt > 1);
    bus        = (cnt == 1) ? sel_or : '0;
  end

  assign alu_op = alu_decode(addsub, xorctrl);

  always_comb begin
    sum = '0;
    case (alu_op)
      ALU_ADD: sum = {1'b0, a_q} + {1'b0, bus};
      ALU_SUB: sum = {1'b0, a_q} + {1'b0, ~bus} + {{WIDTH{1'b0}}, 1'b1};
      ALU_XOR: sum = {1'b0, a_q ^ bus};
      default: sum = '0;
    endcase
  end

  assign alu_res   = sum[WIDTH-1:0];
  assign alu_carry = sum[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (gin) begin
      flag_z <= (alu_res == '0);
      flag_n <= alu_res[WIDTH-1];
      flag_c <= alu_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc_q <= {WIDTH{RST_BIT}};
    else if (pcin)   pc_q <= bus;
    else if (pc_inc) pc_q <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             bus_err <= 1'b0;
    else if (contention) bus_err <= 1'b1;
  end

  assign instr_addr = pc_q;

endmodule
